tick_generator: RTL and testbench

Multi-channel programmable tick and clock-enable generator for the stopwatch datapath, the parametrised successor to the fixed single-rate divider. Each of NUM_CH channels divides `clk_in` by a runtime-loadable divisor and produces a one-cycle `tick` strobe plus a 50% duty `clk_out` square wave. Divisor changes are deferred to the channel's wrap point so no output ever shows a runt period. It sits between the board clock and the stopwatch counters, display multiplexer and debouncers.

---
 rtl/tick_gen_pkg.sv | 17 +
 rtl/tick_channel.sv | 105 ++++++++++
 rtl/tick_generator.sv | 44 ++++
 tb/tb_tick_generator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the tick generator channels.
package tick_gen_pkg;

  localparam int unsigned DEFAULT_DIV_1MS = 100000;
  localparam int unsigned DIV_1S          = 100000000;
  localparam int unsigned DIV_REFRESH     = 100000;
  localparam int unsigned CNT_W_DEFAULT   = 28;

  // What a channel does on a given edge, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_RUN,
    ACT_STOP,
    ACT_CLEAR
  } ch_act_e;

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, active/pending divisor and apply logic.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1MS
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_data,
  output logic             div_busy,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] pending_div;
  logic             busy;

  ch_act_e          act;
  logic             wrap;
  logic             apply_slot;
  logic [CNT_W-1:0] cnt_nx;
  logic             tick_nx;
  logic             clk_nx;

  // Select this edge's action and compute next counter/output values.
  always_comb begin
    act     = ACT_HOLD;
    cnt_nx  = cnt;
    tick_nx = 1'b0;
    clk_nx  = clk_out;
    if (clear)                act = ACT_CLEAR;
    else if (active_div == '0) act = ACT_STOP;
    else if (enable)          act = ACT_RUN;

    wrap = (cnt == (active_div - CNT_W'(1)));
    // Every cycle other than a mid-period run cycle is a safe point to swap divisors.
    apply_slot = (act != ACT_RUN) || wrap;

    case (act)
      ACT_CLEAR: begin
        cnt_nx = '0;
        clk_nx = 1'b0;
      end
      ACT_STOP: begin
        cnt_nx = '0;
      end
      ACT_RUN: begin
        if (wrap) begin
          cnt_nx  = '0;
          tick_nx = 1'b1;
          clk_nx  = ~clk_out;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nx = cnt;
      end
    endcase
  end

  // Counter and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      tick    <= tick_nx;
      clk_out <= clk_nx;
    end
  end

  // Divisor registers; a write landing on an apply slot bypasses the pending stage.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      active_div  <= RST_DIV;
      pending_div <= RST_DIV;
      busy        <= 1'b0;
    end else if (div_wr) begin
      pending_div <= div_data;
      if (apply_slot) begin
        active_div <= div_data;
        busy       <= 1'b0;
      end else begin
        busy <= 1'b1;
      end
    end else if (apply_slot && busy) begin
      active_div <= pending_div;
      busy       <= 1'b0;
    end
  end

  assign div_busy = busy;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable tick / clock-enable generator.
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1MS,
  parameter int unsigned SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] clear,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] div_busy,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic [NUM_CH-1:0] wr_vec;

  // Decode the write strobe per channel; out-of-range selects match nothing.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_vec[i] = div_wr && (div_sel == SEL_W'(i));

    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .enable   (enable[i]),
      .clear    (clear[i]),
      .div_wr   (wr_vec[i]),
      .div_data (div_data),
      .div_busy (div_busy[i]),
      .tick     (tick[i]),
      .clk_out  (clk_out[i])
    );
  end

endmodule

// File: tb/tb_tick_generator.sv
// Directed testbench for tick_generator (3 channels, DEFAULT_DIV=10).
module tb_tick_generator;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 28;
  localparam int unsigned SEL_W  = 2;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] clear;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] div_busy;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  int total = 0;
  int bad   = 0;

  tick_generator #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (10)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (clear),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_data (div_data),
    .div_busy (div_busy),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wr(input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] data);
    div_wr   = 1'b1;
    div_sel  = sel;
    div_data = data;
    step(1);
    div_wr   = 1'b0;
  endtask

  // Count edges until tick[0] rises; a missing tick reports 999.
  task automatic wait_tick(input string tag, input int exp);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk_in);
      #1;
      n++;
      if (tick[0]) begin
        hit = 1'b1;
        break;
      end
    end
    chk(tag, hit ? n : 999, exp);
  endtask

  initial begin
    int  gap_ticks;
    logic exp_clk;

    rst_n    = 1'b0;
    enable   = '0;
    clear    = '0;
    div_wr   = 1'b0;
    div_sel  = '0;
    div_data = '0;
    #1;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_busy", 32'(div_busy), 0);

    // Default rate
    #22;
    rst_n  = 1'b1;
    enable = 3'b001;
    wait_tick("def_t1", 10);
    chk("def_clk1", 32'(clk_out[0]), 1);
    step(1);
    chk("def_onecyc", 32'(tick[0]), 0);
    wait_tick("def_t2", 9);
    chk("def_clk2", 32'(clk_out[0]), 0);
    wait_tick("def_t3", 10);
    chk("def_clk3", 32'(clk_out[0]), 1);

    // Deferred update: write D=4 while cnt=3
    step(3);
    wr(0, 4);
    chk("dfr_busy_hi", 32'(div_busy[0]), 1);
    wait_tick("dfr_old", 6);
    chk("dfr_busy_lo", 32'(div_busy[0]), 0);
    wait_tick("dfr_new1", 4);
    wait_tick("dfr_new2", 4);

    // Back to D=10, then write D=5 on the wrap cycle
    wr(0, 10);
    wait_tick("wrp_prep", 3);
    step(9);
    wr(0, 5);
    chk("wrp_tick", 32'(tick[0]), 1);
    chk("wrp_busy", 32'(div_busy[0]), 0);
    wait_tick("wrp_next", 5);

    // Enable gap with D=8
    wr(0, 8);
    wait_tick("gap_prep", 4);
    step(5);
    enable[0] = 1'b0;
    gap_ticks = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (tick[0]) gap_ticks++;
    end
    chk("gap_noticks", 32'(gap_ticks), 0);
    enable[0] = 1'b1;
    wait_tick("gap_resume", 3);

    // Clear restarts the period and drops clk_out
    chk("clr_pre_clk", 32'(clk_out[0]), 1);
    step(3);
    clear[0] = 1'b1;
    step(1);
    clear[0] = 1'b0;
    chk("clr_clk", 32'(clk_out[0]), 0);
    chk("clr_tick", 32'(tick[0]), 0);
    wait_tick("clr_next", 8);
    chk("clr_clk_after", 32'(clk_out[0]), 1);

    // D=1 written while disabled applies at once
    enable[0] = 1'b0;
    wr(0, 1);
    chk("d1_busy", 32'(div_busy[0]), 0);
    enable[0] = 1'b1;
    exp_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      exp_clk = ~exp_clk;
      chk("d1_tick", 32'(tick[0]), 1);
      chk("d1_clk", 32'(clk_out[0]), 32'(exp_clk));
    end

    // D=0 stops the channel
    wr(0, 0);
    chk("d0_lasttick", 32'(tick[0]), 1);
    gap_ticks = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (tick[0]) gap_ticks++;
    end
    chk("d0_noticks", 32'(gap_ticks), 0);
    wr(0, 3);
    chk("d3_busy", 32'(div_busy[0]), 0);
    wait_tick("d3_t1", 3);
    wait_tick("d3_t2", 3);

    // Out-of-range select touches nothing
    wr(3, 7);
    chk("oor_busy", 32'(div_busy), 0);
    wait_tick("oor_rate", 2);

    // Async reset mid-period with a pending divisor
    wr(0, 10);
    wait_tick("ar_prep", 2);
    step(3);
    wr(0, 5);
    step(2);
    chk("ar_busy_pre", 32'(div_busy[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_tick", 32'(tick), 0);
    chk("ar_clk", 32'(clk_out), 0);
    chk("ar_busy", 32'(div_busy), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    wait_tick("ar_first", 10);
    chk("ar_busy_post", 32'(div_busy[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
